// File: rtl/uart_rx_if.sv
// Receive-side output bundle of uart_rx: received byte, status pulses and busy.
// Carries parity_err_o only when UART_RX_PARITY_EN is defined.
interface uart_rx_if;
    logic [7:0] rx_data_o;
    logic       recv_flag_o;
    logic       frame_err_o;
    logic       busy_o;
`ifdef UART_RX_PARITY_EN
    logic       parity_err_o;

    modport master (output rx_data_o, recv_flag_o, frame_err_o, busy_o, parity_err_o);
    modport slave  (input  rx_data_o, recv_flag_o, frame_err_o, busy_o, parity_err_o);
`else
    modport master (output rx_data_o, recv_flag_o, frame_err_o, busy_o);
    modport slave  (input  rx_data_o, recv_flag_o, frame_err_o, busy_o);
`endif
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first, with an internal bit-period counter.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err_o pulse.
module uart_rx #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      ttl_rx_i,
    uart_rx_if.master bus
);
    localparam int unsigned BIT_CNT  = CLK_FREQ / BAUD;
    localparam int unsigned HALF_CNT = BIT_CNT / 2;
    localparam int unsigned CntW     = $clog2(BIT_CNT);

    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop, StWaitHigh
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      sync_q;
    logic [CntW-1:0] cnt_q, cnt_d, term_cnt;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            recv_q, recv_d;
    logic            ferr_q, ferr_d;
    logic            rx_s, rx_d, fall, tick;
`ifdef UART_RX_PARITY_EN
    logic            par_q, par_d;
    logic            perr_q, perr_d;
`endif

    // sync_q[1] is the two-flop synchronised line, sync_q[2] its one-cycle delay
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 3'b111;
        else     sync_q <= {sync_q[1:0], ttl_rx_i};
    end

    assign rx_s     = sync_q[1];
    assign rx_d     = sync_q[2];
    assign fall     = rx_d & ~rx_s;
    assign term_cnt = (state_q == StStart) ? CntW'(HALF_CNT - 1) : CntW'(BIT_CNT - 1);
    assign tick     = (state_q != StIdle) && (state_q != StWaitHigh) && (cnt_q == term_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (fall) state_d = StStart;
            StStart:    if (tick) state_d = rx_s ? StIdle : StData;
            StData: begin
                if (tick && bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StStop;
`endif
                end
            end
            StParity:   if (tick) state_d = StStop;
            StStop:     if (tick) state_d = rx_s ? StIdle : StWaitHigh;
            StWaitHigh: if (rx_s) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d     = (state_d != state_q || tick || state_q == StIdle) ? '0 : cnt_q + CntW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        recv_d    = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d     = par_q;
        perr_d    = 1'b0;
`endif
        if (tick) begin
            unique case (state_q)
                StData: begin
                    shift_d[bit_idx_q] = rx_s;
                    bit_idx_d          = bit_idx_q + 3'd1;
                end
`ifdef UART_RX_PARITY_EN
                StParity: par_d = rx_s;
`endif
                StStop: begin
                    if (!rx_s) begin
                        ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (^{shift_q, par_q}) begin
                        perr_d = 1'b1;
`endif
                    end else begin
                        recv_d = 1'b1;
                        data_d = shift_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            recv_q    <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            recv_q    <= recv_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign bus.rx_data_o    = data_q;
    assign bus.recv_flag_o  = recv_q;
    assign bus.frame_err_o  = ferr_q;
    assign bus.busy_o       = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err_o = perr_q;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected events, a monitor pops on each pulse.
// Honours UART_RX_PARITY_EN when defined.
module tb_uart_rx;
    localparam int unsigned BIT_CNT = 50000000 / 115200;
    localparam int KRecv = 0, KFerr = 1, KPerr = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ttl_rx = 1'b1;

    uart_rx_if rx_bus ();

    uart_rx dut (
        .clk      (clk),
        .rst      (rst),
        .ttl_rx_i (ttl_rx),
        .bus      (rx_bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int exp_kind[$];
    logic [7:0] exp_data[$];
    logic [7:0] last_good = 8'h00;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        ttl_rx = b;
        repeat (BIT_CNT) @(negedge clk);
    endtask

    // Reference model: framing rules decide which single event the frame must produce.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic par_ok);
        int kind;
        if (!stop_ok) kind = KFerr;
`ifdef UART_RX_PARITY_EN
        else if (!par_ok) kind = KPerr;
`endif
        else kind = KRecv;
        exp_kind.push_back(kind);
        exp_data.push_back(d);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ ~par_ok);
`endif
        drive_bit(stop_ok);
    endtask

    logic perr;
`ifdef UART_RX_PARITY_EN
    assign perr = rx_bus.parity_err_o;
`else
    assign perr = 1'b0;
`endif

    always @(negedge clk) begin
        if (!rst && (rx_bus.recv_flag_o || rx_bus.frame_err_o || perr)) begin
            int got, k;
            logic [7:0] d;
            got = rx_bus.recv_flag_o ? KRecv : (rx_bus.frame_err_o ? KFerr : KPerr);
            check("flags_exclusive", int'(rx_bus.recv_flag_o) + int'(rx_bus.frame_err_o)
                  + int'(perr), 1);
            if (exp_kind.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got kind %0d expected none", got);
            end else begin
                k = exp_kind.pop_front();
                d = exp_data.pop_front();
                check("event_kind", got, k);
                if (got == KRecv) begin
                    check("rx_data", rx_bus.rx_data_o, d);
                    check("busy_at_flag", rx_bus.busy_o, 0);
                    if (k == KRecv) last_good = d;
                end else begin
                    check("rx_data_hold", rx_bus.rx_data_o, last_good);
                end
            end
        end
    end

    initial begin
        logic [7:0] c3;
        logic [7:0] rd;
        logic so, po;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_data", rx_bus.rx_data_o, 0);
        check("reset_recv", rx_bus.recv_flag_o, 0);
        check("reset_ferr", rx_bus.frame_err_o, 0);
        check("reset_busy", rx_bus.busy_o, 0);

        send_frame(8'hA5, 1'b1, 1'b1);
        drive_bit(1'b1);

        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b1);
        drive_bit(1'b1);

        // Short low glitch: must abort at the mid-start sample
        ttl_rx = 1'b0;
        repeat (100) @(negedge clk);
        ttl_rx = 1'b1;
        repeat (50) @(negedge clk);
        check("glitch_busy_high", rx_bus.busy_o, 1);
        repeat (110) @(negedge clk);
        check("glitch_busy_low", rx_bus.busy_o, 0);
        check("glitch_data", rx_bus.rx_data_o, last_good);

        send_frame(8'h55, 1'b0, 1'b1);
        ttl_rx = 1'b0;
        repeat (3000) @(negedge clk);
        drive_bit(1'b1);
        drive_bit(1'b1);
        send_frame(8'h12, 1'b1, 1'b1);
        drive_bit(1'b1);

        // Reset in the middle of bit 4 of 8'hC3
        c3 = 8'hC3;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(c3[i]);
        ttl_rx = c3[4];
        repeat (BIT_CNT / 2) @(negedge clk);
        rst = 1'b1;
        ttl_rx = 1'b1;
        last_good = 8'h00;
        repeat (3) @(negedge clk);
        check("midreset_busy", rx_bus.busy_o, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset_data", rx_bus.rx_data_o, 0);
        drive_bit(1'b1);
        send_frame(8'h7E, 1'b1, 1'b1);
        drive_bit(1'b1);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h01, 1'b1, 1'b1);
        drive_bit(1'b1);
        send_frame(8'h01, 1'b1, 1'b0);
        drive_bit(1'b1);
`endif

        for (int i = 0; i < 4; i++) begin
            rd = 8'($urandom);
            so = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
            po = ($urandom_range(0, 3) != 0);
`else
            po = 1'b1;
`endif
            send_frame(rd, so, po);
            if (!so) begin
                drive_bit(1'b1);
                drive_bit(1'b1);
            end
        end

        begin
            int waited = 0;
            while (exp_kind.size() != 0 && waited < 10000) begin
                @(negedge clk);
                waited++;
            end
        end
        repeat (10) @(negedge clk);
        check("all_events_seen", exp_kind.size(), 0);
        check("final_data", rx_bus.rx_data_o, last_good);
        check("final_busy", rx_bus.busy_o, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
